// File: rtl/latch_bank_arbiter_if.sv
// Requester and latch-bank signal bundle for latch_bank_arbiter.
// The master side drives requests; the slave side (the arbiter) drives
// completion strobes and the latch D/enable bus.
interface latch_bank_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) ();
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int GID_W  = $clog2(N_REQ);

  logic [N_REQ-1:0]        req;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        ack;
  logic                    err;
  logic                    busy;
  logic [GID_W-1:0]        grant_id;
  logic [DATA_W-1:0]       lat_d;
  logic [DEPTH-1:0]        lat_en;

  modport master (
    output req, req_addr, req_data,
    input  ack, err, busy, grant_id, lat_d, lat_en
  );

  modport slave (
    input  req, req_addr, req_data,
    output ack, err, busy, grant_id, lat_d, lat_en
  );
endinterface

// File: rtl/latch_bank_arbiter.sv
// Round-robin arbiter that serialises writes into a bank of level-sensitive
// latch words. Each write runs SETUP -> OPEN (OPEN_CYC cycles) -> HOLD so the
// latch D bus is stable before, during and after its enable window.
// Every output, including the latch enables, comes straight from a flop.
module latch_bank_arbiter #(
  parameter int N_REQ    = 4,
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 8,
  parameter int OPEN_CYC = 2
) (
  input logic                  clk,
  input logic                  rest,
  latch_bank_arbiter_if.slave  bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int GID_W  = $clog2(N_REQ);
  localparam int CNT_W  = (OPEN_CYC > 1) ? $clog2(OPEN_CYC) : 1;

  localparam logic [ADDR_W:0]    DEPTH_LIM = (ADDR_W+1)'(DEPTH);
  localparam logic [GID_W:0]     NREQ_V    = (GID_W+1)'(N_REQ);
  localparam logic [GID_W-1:0]   GID_LAST  = GID_W'(N_REQ - 1);
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(OPEN_CYC - 1);

  typedef enum logic [1:0] {IDLE, SETUP, OPEN, HOLD} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [GID_W-1:0]    ptr_q, ptr_d;
  logic [GID_W-1:0]    gid_q, gid_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   dat_q, dat_d;
  logic [DEPTH-1:0]    en_q, en_d;
  logic [N_REQ-1:0]    ack_q, ack_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;

  logic                found_c;
  logic [GID_W-1:0]    win_c;
  logic [GID_W:0]      cand_c;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_data;

  // Round-robin search: first pending request at or after the pointer, wrapping.
  always_comb begin
    found_c = 1'b0;
    win_c   = '0;
    cand_c  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand_c = {1'b0, ptr_q} + (GID_W+1)'(k);
      if (cand_c >= NREQ_V) cand_c = cand_c - NREQ_V;
      if (!found_c && bus.req[cand_c[GID_W-1:0]]) begin
        found_c = 1'b1;
        win_c   = cand_c[GID_W-1:0];
      end
    end
  end

  // Pick the winning requester's address and data out of the packed buses.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_c == GID_W'(i)) begin
        sel_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
        sel_data = bus.req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Sequencer next state; address/data are captured only on the IDLE->SETUP edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    gid_d   = gid_q;
    addr_d  = addr_q;
    dat_d   = dat_q;
    unique case (state_q)
      IDLE: begin
        if (found_c) begin
          state_d = SETUP;
          gid_d   = win_c;
          addr_d  = sel_addr;
          dat_d   = sel_data;
        end
      end
      SETUP: begin
        state_d = OPEN;
        cnt_d   = '0;
      end
      OPEN: begin
        if (cnt_q == CNT_LAST) state_d = HOLD;
        else                   cnt_d   = cnt_q + CNT_W'(1);
      end
      HOLD: begin
        state_d = IDLE;
        ptr_d   = (gid_q == GID_LAST) ? '0 : gid_q + GID_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // Output values for the coming cycle, decoded from the next state so they register cleanly.
  always_comb begin
    busy_d = (state_d != IDLE);
    en_d   = '0;
    ack_d  = '0;
    err_d  = 1'b0;
    if (state_d == OPEN) begin
      for (int i = 0; i < DEPTH; i++) en_d[i] = (addr_d == ADDR_W'(i));
    end
    if (state_d == HOLD) begin
      for (int i = 0; i < N_REQ; i++) ack_d[i] = (gid_d == GID_W'(i));
      err_d = ({1'b0, addr_d} >= DEPTH_LIM);
    end
  end

  // Control and output flops; reset abandons any write and drops the enables at once.
  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      gid_q   <= '0;
      dat_q   <= '0;
      en_q    <= '0;
      ack_q   <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      dat_q   <= dat_d;
      en_q    <= en_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  // Captured target address; only consulted after a grant, so it needs no reset.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
  end

  assign bus.ack      = ack_q;
  assign bus.err      = err_q;
  assign bus.busy     = busy_q;
  assign bus.grant_id = gid_q;
  assign bus.lat_d    = dat_q;
  assign bus.lat_en   = en_q;
endmodule

// File: tb/tb_latch_bank_arbiter.sv
// Bench for latch_bank_arbiter: instance A (DEPTH=6, OPEN_CYC=2) and
// instance B (DEPTH=8, OPEN_CYC=1) share clock, reset and request stimulus.
// A transaction-level model predicts every output each cycle; directed
// sequences add hand-computed literal expectations.
module tb_latch_bank_arbiter;
  localparam int NR = 4;

  logic clk  = 1'b0;
  logic rest = 1'b0;

  int n_chk  = 0;
  int n_pass = 0;

  logic [3:0]  reqv;
  logic [11:0] addrv;
  logic [31:0] datav;

  latch_bank_arbiter_if #(.N_REQ(4), .DATA_W(8), .DEPTH(6)) ia ();
  latch_bank_arbiter_if #(.N_REQ(4), .DATA_W(8), .DEPTH(8)) ib ();

  latch_bank_arbiter #(.N_REQ(4), .DATA_W(8), .DEPTH(6), .OPEN_CYC(2)) dut_a (
    .clk(clk), .rest(rest), .bus(ia)
  );
  latch_bank_arbiter #(.N_REQ(4), .DATA_W(8), .DEPTH(8), .OPEN_CYC(1)) dut_b (
    .clk(clk), .rest(rest), .bus(ib)
  );

  always #5 clk = ~clk;

  // t = cycles since grant (0 = idle); the write occupies t = 1 .. oc+2.
  typedef struct {
    int oc;
    int depth;
    int ptr;
    int t;
    int id;
    int addr;
    int d;
  } mdl_t;

  mdl_t ma = '{2, 6, 0, 0, 0, 0, 0};
  mdl_t mb = '{1, 8, 0, 0, 0, 0, 0};

  function automatic mdl_t mreset(mdl_t m);
    m.ptr = 0; m.t = 0; m.id = 0; m.addr = 0; m.d = 0;
    return m;
  endfunction

  function automatic mdl_t mstep(mdl_t m, logic [3:0] r, logic [11:0] av, logic [31:0] dv);
    bit found = 0;
    if (m.t == 0) begin
      for (int k = 0; k < NR; k++) begin
        int idx = (m.ptr + k) % NR;
        if (!found && r[idx]) begin
          found  = 1;
          m.id   = idx;
          m.addr = int'(av[idx*3 +: 3]);
          m.d    = int'(dv[idx*8 +: 8]);
          m.t    = 1;
        end
      end
    end else if (m.t < m.oc + 2) begin
      m.t = m.t + 1;
    end else begin
      m.ptr = (m.id + 1) % NR;
      m.t   = 0;
    end
    return m;
  endfunction

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, act, exp, $time);
  endtask

  task automatic cmp(string nm, mdl_t m, logic busy, logic [7:0] en, logic [7:0] d,
                     logic [3:0] ack, logic err, logic [1:0] gid);
    int e_en, e_ack, e_err;
    e_en  = (m.t >= 2 && m.t <= m.oc + 1 && m.addr < m.depth) ? (1 << m.addr) : 0;
    e_ack = (m.t == m.oc + 2) ? (1 << m.id) : 0;
    e_err = (m.t == m.oc + 2 && m.addr >= m.depth) ? 1 : 0;
    chk({nm, "_busy"},   int'(busy), (m.t != 0) ? 1 : 0);
    chk({nm, "_lat_en"}, int'(en),   e_en);
    chk({nm, "_lat_d"},  int'(d),    m.d);
    chk({nm, "_ack"},    int'(ack),  e_ack);
    chk({nm, "_err"},    int'(err),  e_err);
    chk({nm, "_gid"},    int'(gid),  m.id);
  endtask

  // Advance the model on the same edges the DUT sees.
  always @(posedge clk or negedge rest) begin
    if (!rest) begin
      ma <= mreset(ma);
      mb <= mreset(mb);
    end else begin
      ma <= mstep(ma, ia.req, ia.req_addr, ia.req_data);
      mb <= mstep(mb, ib.req, ib.req_addr, ib.req_data);
    end
  end

  // Compare both instances against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    cmp("A", ma, ia.busy, 8'(ia.lat_en), ia.lat_d, ia.ack, ia.err, ia.grant_id);
    cmp("B", mb, ib.busy, ib.lat_en,     ib.lat_d, ib.ack, ib.err, ib.grant_id);
  end

  task automatic apply();
    ia.req = reqv; ia.req_addr = addrv; ia.req_data = datav;
    ib.req = reqv; ib.req_addr = addrv; ib.req_data = datav;
  endtask

  task automatic set_slot(int i, int a, int d);
    addrv[i*3 +: 3] = 3'(a);
    datav[i*8 +: 8] = 8'(d);
  endtask

  task automatic nxt();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_rest(logic v);
    @(posedge clk);
    #2 rest = v;
    @(negedge clk);
  endtask

  task automatic idle(int n);
    reqv = 4'b0000;
    apply();
    repeat (n) nxt();
  endtask

  initial begin
    int nack;
    int last;
    reqv = '0; addrv = '0; datav = '0;
    apply();
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_busy",   int'(ia.busy),     0);
    chk("rst_lat_en", int'(ia.lat_en),   0);
    chk("rst_lat_d",  int'(ia.lat_d),    0);
    chk("rst_ack",    int'(ia.ack),      0);
    chk("rst_err",    int'(ia.err),      0);
    chk("rst_gid",    int'(ia.grant_id), 0);
    set_rest(1'b1);
    nxt();

    // Single write, requester 0, addr 5, data 0xA5
    set_slot(0, 5, 8'hA5); reqv = 4'b0001; apply();
    nxt();
    chk("t1_c1_lat_d",  int'(ia.lat_d),  8'hA5);
    chk("t1_c1_busy",   int'(ia.busy),   1);
    chk("t1_c1_lat_en", int'(ia.lat_en), 0);
    nxt();
    chk("t1_c2_lat_en", int'(ia.lat_en), 8'h20);
    nxt();
    chk("t1_c3_lat_en", int'(ia.lat_en), 8'h20);
    chk("t1_c3_ack",    int'(ia.ack),    0);
    nxt();
    chk("t1_c4_ack",    int'(ia.ack),    4'b0001);
    chk("t1_c4_lat_en", int'(ia.lat_en), 0);
    chk("t1_c4_err",    int'(ia.err),    0);
    idle(6);

    // All four requesting continuously from a fresh pointer
    set_rest(1'b0);
    nxt();
    set_rest(1'b1);
    for (int i = 0; i < 4; i++) set_slot(i, i, 8'h10 + i);
    reqv = 4'b1111; apply();
    nack = 0;
    last = 0;
    for (int c = 1; c <= 30 && nack < 5; c++) begin
      nxt();
      if (ia.ack != 0) begin
        chk("rr_ack_id", int'(ia.ack), 1 << (nack % 4));
        if (nack == 0) chk("rr_first_ack_cycle", c, 4);
        else           chk("rr_ack_gap", c - last, 5);
        last = c;
        nack++;
      end
    end
    chk("rr_ack_count", nack, 5);
    idle(6);

    // Requester 2 alone; its inputs change mid-write. B covers OPEN_CYC=1.
    addrv = '0; datav = '0;
    set_slot(2, 4, 8'h3C); reqv = 4'b0100; apply();
    nxt();
    chk("t3_c1_lat_en", int'(ia.lat_en), 0);
    chk("t3_c1_lat_d",  int'(ia.lat_d),  8'h3C);
    chk("t3_c1_gid",    int'(ia.grant_id), 2);
    chk("t6_c1_lat_en", int'(ib.lat_en), 0);
    nxt();
    chk("t3_c2_lat_en", int'(ia.lat_en), 8'h10);
    chk("t6_c2_lat_en", int'(ib.lat_en), 8'h10);
    set_slot(2, 1, 8'hFF); apply();
    nxt();
    chk("t3_c3_lat_en", int'(ia.lat_en), 8'h10);
    chk("t3_c3_lat_d",  int'(ia.lat_d),  8'h3C);
    chk("t6_c3_lat_en", int'(ib.lat_en), 0);
    chk("t6_c3_ack",    int'(ib.ack),    4'b0100);
    nxt();
    chk("t3_c4_ack",    int'(ia.ack),    4'b0100);
    chk("t3_c4_lat_en", int'(ia.lat_en), 0);
    chk("t3_c4_lat_d",  int'(ia.lat_d),  8'h3C);
    idle(6);

    // Out-of-range address on A (DEPTH=6), then a normal write
    addrv = '0; datav = '0;
    set_slot(0, 7, 8'h77); reqv = 4'b0001; apply();
    nxt();
    nxt();
    chk("t4_c2_lat_en", int'(ia.lat_en), 0);
    nxt();
    chk("t4_c3_lat_en", int'(ia.lat_en), 0);
    nxt();
    chk("t4_c4_ack", int'(ia.ack), 4'b0001);
    chk("t4_c4_err", int'(ia.err), 1);
    idle(3);
    set_slot(1, 2, 8'h22); reqv = 4'b0010; apply();
    nxt();
    nxt();
    chk("t4b_c2_lat_en", int'(ia.lat_en), 8'h04);
    nxt();
    nxt();
    chk("t4b_c4_ack", int'(ia.ack), 4'b0010);
    chk("t4b_c4_err", int'(ia.err), 0);
    idle(6);

    // Reset in the middle of an OPEN window
    set_slot(3, 3, 8'h33); reqv = 4'b1000; apply();
    nxt();
    nxt();
    chk("t5_c2_lat_en", int'(ia.lat_en), 8'h08);
    @(posedge clk);
    #2 rest = 1'b0;
    #1;
    chk("t5_rst_lat_en", int'(ia.lat_en), 0);
    chk("t5_rst_busy",   int'(ia.busy),   0);
    chk("t5_rst_ack",    int'(ia.ack),    0);
    @(negedge clk);
    nxt();
    chk("t5_hold_ack",  int'(ia.ack),  0);
    chk("t5_hold_busy", int'(ia.busy), 0);
    set_rest(1'b1);
    nxt();
    chk("t5_r1_gid",   int'(ia.grant_id), 3);
    chk("t5_r1_busy",  int'(ia.busy),     1);
    chk("t5_r1_lat_d", int'(ia.lat_d),    8'h33);
    nxt();
    nxt();
    nxt();
    chk("t5_r4_ack", int'(ia.ack), 4'b1000);
    idle(6);

    // Randomized traffic checked by the model
    for (int c = 0; c < 800; c++) begin
      reqv  = 4'($urandom);
      addrv = 12'($urandom);
      datav = $urandom;
      apply();
      @(negedge clk);
    end
    idle(4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/latch_bank_arbiter.md
Name: latch_bank_arbiter

Overview:
- Sequences and shares a bank of DEPTH level-sensitive D-latch words (gated-NAND latch cells, transparent while enable is high) between N_REQ requesters.
- Round-robin arbitration selects one write at a time.
- A setup / open / hold FSM guarantees latch data is stable before, during and after each enable window, so no latch ever sees D change while transparent.
- Sits between the requesting logic and the latch bank's D and enable inputs.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DATA_W, 8, latch word width.
- DEPTH, 8, number of latch words (2..16; need not be a power of 2).
- ADDR_W, $clog2(DEPTH), address width (derived, not overridden).
- OPEN_CYC, 2, cycles the selected latch enable stays high (>=1).

Ports:
- clk  in  1  single system clock, rising edge.
- rest  in  1  asynchronous, active-low reset.
- req  in  N_REQ  per-requester write request, level, held until ack.
- req_addr  in  N_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W].
- req_data  in  N_REQ*DATA_W  packed write data; requester i at [i*DATA_W +: DATA_W].
- ack  out  N_REQ  one-cycle completion pulse to the granted requester.
- err  out  1  one-cycle pulse with ack when the captured address >= DEPTH.
- busy  out  1  high in every state except IDLE.
- grant_id  out  $clog2(N_REQ)  index of the current or most recent grantee.
- lat_d  out  DATA_W  data bus to all latch D inputs.
- lat_en  out  DEPTH  one-hot latch enables; all zero outside OPEN.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low on port rest.
- While rest=0, all of the following are 0:
  - state=IDLE, lat_en, lat_d, ack, err, busy, grant_id.
  - RR pointer=0.
- The lat_en clear is immediate (asynchronous). A write interrupted by reset is abandoned, no ack is issued, and the requester keeps req high and is re-served after reset.
- All outputs are registered. lat_en comes directly from flops and is glitch-free.
- State IDLE:
  - If any req bit is set, grant the first set bit searching from ptr upward mod N_REQ.
  - Capture that requester's addr and data into internal registers and set grant_id.
  - Go to SETUP. Otherwise stay in IDLE.
- State SETUP (1 cycle): lat_d = captured data, lat_en = 0, busy = 1. Go to OPEN.
- State OPEN (OPEN_CYC cycles, internal counter):
  - lat_en[addr] = 1 when addr < DEPTH; otherwise lat_en stays 0.
  - lat_d is held. Then go to HOLD.
- State HOLD (1 cycle):
  - lat_en = 0, lat_d still held.
  - ack[grant_id] = 1; err = 1 if addr >= DEPTH.
  - ptr <= grant_id+1 mod N_REQ. Go to IDLE.
- lat_d keeps its last value in IDLE. It changes only on the IDLE->SETUP edge.
- Latency: req sampled in IDLE at cycle 0. Outputs follow on successive clock edges:
  - cycle 1: SETUP.
  - cycles 2..OPEN_CYC+1: OPEN.
  - cycle OPEN_CYC+2: HOLD, ack.
  - Total is OPEN_CYC+2 cycles from grant to ack (4 at default).
- Throughput: one write per OPEN_CYC+3 cycles. The IDLE cycle between writes is mandatory.
- Requesters must drop req in the cycle after ack. A req still high in the IDLE cycle after ack is treated as a new request. Because the pointer has advanced, other pending requesters win first.
- Changes to req_addr or req_data after grant are ignored.
- Dropping req before ack does not abort the write; ack is still pulsed.
- Simultaneous requests: exactly one grant. Every continuously-requesting requester is served within N_REQ writes (no starvation).
- Exactly one lat_en bit is high at any time, or none.

Test Plan:
- Reset, then req=0001, addr0=5, data0=0xA5. Required:
  - SETUP at cycle 1 with lat_d=0xA5.
  - lat_en=0x20 during cycles 2-3.
  - ack=0001 at cycle 4.
  - lat_en=0 in cycles 1 and 4.
- req=1111 held continuously, distinct addrs/data. Required:
  - Grant order 0,1,2,3,0.
  - One ack every 5 cycles.
  - Each lat_en pulse lasts exactly 2 cycles, on the matching address.
- Grant requester 2, then change req_data[2] and req_addr[2] during OPEN. Required: lat_d and lat_en keep the captured values until HOLD completes.
- DEPTH=6, write to addr=7. Required:
  - lat_en stays 0 throughout.
  - ack and err pulse together at cycle 4.
  - The next normal write has err=0.
- Drop rest to 0 mid-OPEN on a write to addr 3. Required:
  - lat_en=0 before the next clock edge; busy=0; no ack.
  - After rest returns high with req still set, the write completes normally with ptr restarting at 0.
- OPEN_CYC=1, req=0100. Required: lat_en high for exactly 1 cycle and ack at cycle 3.
